// File: rtl/sysid_check_master.sv
`default_nettype none
// ============================================================================
// Module   : sysid_check_master
// Brief    : Avalon-MM read initiator that fetches the system ID (word 0) and
//            the build timestamp (word 1) from the sysid slave, compares them
//            against build-time values and publishes a boot pass/fail verdict.
// Revision : 1.0 - initial release
// ============================================================================
module sysid_check_master #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] MIN_TIMESTAMP  = 32'd1498439491,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter int          MAX_RETRIES    = 3,
    parameter bit          AUTO_START     = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic        avm_readdatavalid,
    input  logic [31:0] avm_readdata,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout_err,
    output logic [31:0] id_out,
    output logic [31:0] timestamp_out
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ_ID  = 3'd1,
        S_WAIT_ID = 3'd2,
        S_REQ_TS  = 3'd3,
        S_WAIT_TS = 3'd4,
        S_CHECK   = 3'd5,
        S_FINISH  = 3'd6
    } state_t;

    // The timeout fires on the edge where the counter would reach TIMEOUT_CYCLES.
    localparam logic [15:0] c_tmo_last  = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]  c_max_retry = 4'(MAX_RETRIES);

    state_t      r_state;
    logic [15:0] r_tmo_cnt;
    logic [3:0]  r_retry;
    logic        r_gap;      // one-cycle read drop before a re-issue
    logic        r_auto;     // pending automatic start after reset release
    logic        r_read;
    logic        r_address;
    logic        r_busy;
    logic        r_done;
    logic        r_pass;
    logic        r_timeout_err;
    logic [31:0] r_id;
    logic [31:0] r_ts;

    logic w_req_state;
    logic w_wait_state;
    logic w_ts_phase;
    logic w_accept;
    logic w_data_now;
    logic w_expired;
    logic w_go;

    assign w_req_state  = (r_state == S_REQ_ID) || (r_state == S_REQ_TS);
    assign w_wait_state = (r_state == S_WAIT_ID) || (r_state == S_WAIT_TS);
    assign w_ts_phase   = (r_state == S_REQ_TS) || (r_state == S_WAIT_TS);
    assign w_accept     = w_req_state && !r_gap && !avm_waitrequest;
    // Data is only taken on the accept edge (zero-latency slave) or while waiting;
    // any other readdatavalid is a stale response and is ignored.
    assign w_data_now   = avm_readdatavalid && (w_accept || w_wait_state);
    assign w_expired    = (r_tmo_cnt >= c_tmo_last);
    assign w_go         = start || r_auto;

    // Check sequencer: issues both reads, handles timeouts/retries and forms the verdict.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_tmo_cnt     <= 16'd0;
            r_retry       <= 4'd0;
            r_gap         <= 1'b0;
            r_auto        <= AUTO_START;
            r_read        <= 1'b0;
            r_address     <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_id          <= 32'd0;
            r_ts          <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_go) begin
                        r_auto        <= 1'b0;
                        r_busy        <= 1'b1;
                        r_done        <= 1'b0;
                        r_pass        <= 1'b0;
                        r_timeout_err <= 1'b0;
                        r_retry       <= 4'd0;
                        r_tmo_cnt     <= 16'd0;
                        r_gap         <= 1'b0;
                        r_read        <= 1'b1;
                        r_address     <= 1'b0;
                        r_state       <= S_REQ_ID;
                    end
                end
                S_REQ_ID, S_WAIT_ID, S_REQ_TS, S_WAIT_TS: begin
                    if (w_req_state && r_gap) begin
                        r_gap  <= 1'b0;
                        r_read <= 1'b1;
                    end else if (w_data_now) begin
                        r_retry   <= 4'd0;
                        r_tmo_cnt <= 16'd0;
                        if (w_ts_phase) begin
                            r_ts    <= avm_readdata;
                            r_read  <= 1'b0;
                            r_state <= S_CHECK;
                        end else begin
                            r_id      <= avm_readdata;
                            r_read    <= 1'b1;
                            r_address <= 1'b1;
                            r_state   <= S_REQ_TS;
                        end
                    end else if (w_accept) begin
                        r_read    <= 1'b0;
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                        r_state   <= w_ts_phase ? S_WAIT_TS : S_WAIT_ID;
                    end else if (w_expired) begin
                        r_read <= 1'b0;
                        if (r_retry == c_max_retry) begin
                            r_timeout_err <= 1'b1;
                            r_pass        <= 1'b0;
                            r_state       <= S_FINISH;
                        end else begin
                            r_retry   <= r_retry + 4'd1;
                            r_gap     <= 1'b1;
                            r_tmo_cnt <= 16'd0;
                            r_state   <= w_ts_phase ? S_REQ_TS : S_REQ_ID;
                        end
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 16'd1;
                    end
                end
                S_CHECK: begin
                    r_pass  <= (r_id == EXPECTED_ID) && (r_ts >= MIN_TIMESTAMP);
                    r_state <= S_FINISH;
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_read  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign avm_read      = r_read;
    assign avm_address   = r_address;
    assign busy          = r_busy;
    assign done          = r_done;
    assign pass          = r_pass;
    assign timeout_err   = r_timeout_err;
    assign id_out        = r_id;
    assign timestamp_out = r_ts;

endmodule
`default_nettype wire

// File: tb/tb_sysid_check_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sysid_check_master
// Brief    : Scoreboard bench for sysid_check_master with a behavioural Avalon
//            slave, randomized wait/latency/data and a rule-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sysid_check_master;

    localparam logic [31:0] c_exp_id = 32'd0;
    localparam logic [31:0] c_min_ts = 32'd1498439491;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic        avm_readdatavalid = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout_err;
    logic [31:0] id_out;
    logic [31:0] timestamp_out;

    sysid_check_master #(
        .EXPECTED_ID    (c_exp_id),
        .MIN_TIMESTAMP  (c_min_ts),
        .TIMEOUT_CYCLES (8),
        .MAX_RETRIES    (2),
        .AUTO_START     (1'b1)
    ) dut (
        .clock             (clock),
        .reset_n           (reset_n),
        .start             (start),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdatavalid (avm_readdatavalid),
        .avm_readdata      (avm_readdata),
        .busy              (busy),
        .done              (done),
        .pass              (pass),
        .timeout_err       (timeout_err),
        .id_out            (id_out),
        .timestamp_out     (timestamp_out)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] id;
        logic [31:0] ts;
        logic        pass;
        logic        terr;
        int          lat;
        int          t0;
    } exp_t;

    exp_t        sbq[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          nreq0 = 0;
    int          nreq1 = 0;
    int          late_req = 0;
    int          cfg_wait = 0;
    int          cfg_lat = 1;
    bit          cfg_drop = 1'b0;
    logic [31:0] cfg_id = 32'd0;
    logic [31:0] cfg_ts = 32'd1498439491;
    logic [31:0] m_ts = 32'd0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Cycle counter and accepted-request accounting.
    initial begin
        forever begin
            @(posedge clock);
            cyc++;
            if (reset_n && avm_read && !avm_waitrequest) begin
                if (avm_address) nreq1++;
                else nreq0++;
            end
        end
    end

    // Slave model, stall-stability check and scoreboard monitor (all at negedge).
    initial begin
        int          pend = 0;
        int          stall = 0;
        int          late_ack = 0;
        logic [31:0] pdata = 32'd0;
        logic        prev_rd = 1'b0;
        logic        prev_wr = 1'b0;
        logic        prev_addr = 1'b0;
        logic        prev_done = 1'b0;
        exp_t        e;
        forever begin
            @(negedge clock);
            if (reset_n && prev_rd && prev_wr)
                chk("stall_hold", 72'({avm_read, avm_address}), 72'({1'b1, prev_addr}));
            if (reset_n && done && !prev_done) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done actual=1 required=0");
                end else begin
                    e = sbq.pop_front();
                    chk("id_out", 72'(id_out), 72'(e.id));
                    chk("timestamp_out", 72'(timestamp_out), 72'(e.ts));
                    chk("pass", 72'(pass), 72'(e.pass));
                    chk("timeout_err", 72'(timeout_err), 72'(e.terr));
                    if (e.lat >= 0) chk("latency", 72'(cyc - e.t0), 72'(e.lat));
                end
            end
            prev_done = done;
            avm_readdatavalid = 1'b0;
            if (!reset_n) begin
                pend = 0;
                stall = 0;
                avm_waitrequest = 1'b0;
            end else begin
                if (pend > 0) begin
                    pend--;
                    if (pend == 0) begin
                        avm_readdatavalid = 1'b1;
                        avm_readdata = pdata;
                    end
                end
                if (late_ack != late_req) begin
                    late_ack = late_req;
                    avm_readdatavalid = 1'b1;
                    avm_readdata = 32'hDEAD_BEEF;
                end
                if (avm_read) begin
                    if (stall < cfg_wait) begin
                        avm_waitrequest = 1'b1;
                        stall++;
                    end else begin
                        avm_waitrequest = 1'b0;
                        stall = 0;
                        if (!(avm_address && cfg_drop)) begin
                            pdata = avm_address ? cfg_ts : cfg_id;
                            if (cfg_lat == 0) begin
                                avm_readdatavalid = 1'b1;
                                avm_readdata = pdata;
                            end else begin
                                pend = cfg_lat;
                            end
                        end
                    end
                end else begin
                    avm_waitrequest = 1'b0;
                end
            end
            prev_rd = avm_read;
            prev_wr = avm_waitrequest;
            prev_addr = avm_address;
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    // Reference: verdict from the comparison rules, latency from per-read handshake cost.
    function automatic exp_t model(input logic [31:0] id, input logic [31:0] ts,
                                   input int w, input int l, input bit drop);
        exp_t e;
        e.id   = id;
        e.ts   = drop ? m_ts : ts;
        e.terr = drop;
        e.pass = !drop && (id == c_exp_id) && (ts >= c_min_ts);
        e.lat  = drop ? -1 : 2 * (w + 1 + l) + 2;
        e.t0   = 0;
        return e;
    endfunction

    task automatic wait_done();
        int n = 0;
        while (sbq.size() != 0 && n < 2000) begin
            step();
            n++;
        end
        if (sbq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL wait_done actual=timeout required=done");
            sbq.delete();
        end
    endtask

    task automatic issue(input logic [31:0] id, input logic [31:0] ts,
                         input int w, input int l, input bit drop);
        exp_t e;
        cfg_id = id; cfg_ts = ts; cfg_wait = w; cfg_lat = l; cfg_drop = drop;
        e = model(id, ts, w, l, drop);
        if (!drop) m_ts = ts;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        e.t0 = cyc;
        sbq.push_back(e);
        @(negedge clock);
        chk("start_clears", 72'({done, pass, busy}), 72'(3'b001));
    endtask

    task automatic run_check(input logic [31:0] id, input logic [31:0] ts,
                             input int w, input int l, input bit drop);
        issue(id, ts, w, l, drop);
        wait_done();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=hang required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t        e;
        int          n;
        logic [31:0] rid;
        logic [31:0] rts;
        logic [31:0] ts_before;

        // Reset state, then the automatic check after release.
        repeat (3) step();
        @(negedge clock);
        chk("reset_outputs", 72'({avm_read, avm_address, busy, done, pass, timeout_err,
                                  id_out, timestamp_out}), 72'd0);
        e = model(32'd0, c_min_ts, 0, 1, 1'b0);
        m_ts = c_min_ts;
        step();
        reset_n = 1'b1;
        step();
        e.t0 = cyc;
        sbq.push_back(e);
        wait_done();

        // Directed: ID mismatch, stall, timestamp boundaries, zero-latency slave.
        run_check(32'h0000_0001, c_min_ts, 0, 1, 1'b0);
        run_check(32'd0, c_min_ts + 32'd5, 5, 1, 1'b0);
        run_check(32'd0, c_min_ts - 32'd1, 0, 1, 1'b0);
        run_check(32'd0, 32'hFFFF_FFFF, 0, 0, 1'b0);

        // Randomized handshakes and data.
        for (int i = 0; i < 20; i++) begin
            rid = ($urandom_range(0, 1) == 1) ? 32'd0 : $urandom;
            rts = ($urandom_range(0, 1) == 1) ? (c_min_ts + 32'($urandom_range(0, 1000)) - 32'd500)
                                              : $urandom;
            run_check(rid, rts, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
        end

        // Timeout on the timestamp read: three requests, then error; late data ignored.
        n = nreq1;
        run_check(32'd0, 32'h7000_0000, 0, 1, 1'b1);
        chk("ts_requests", 72'(nreq1 - n), 72'd3);
        ts_before = m_ts;
        late_req++;
        repeat (3) step();
        @(negedge clock);
        chk("late_data_ignored", 72'({done, timestamp_out}), 72'({1'b1, ts_before}));

        // Reset while waiting for the timestamp, then auto-rerun.
        n = nreq1;
        issue(32'd0, c_min_ts + 32'd9, 0, 3, 1'b0);
        for (int k = 0; k < 100 && nreq1 == n; k++) step();
        reset_n = 1'b0;
        step();
        @(negedge clock);
        chk("reset_midread", 72'({avm_read, avm_address, busy, done, pass, timeout_err,
                                  id_out, timestamp_out}), 72'd0);
        sbq.delete();
        cfg_lat = 1;
        e = model(32'd0, c_min_ts + 32'd9, 0, 1, 1'b0);
        step();
        reset_n = 1'b1;
        step();
        e.t0 = cyc;
        sbq.push_back(e);
        wait_done();

        // start while busy is ignored; start after done reruns.
        n = nreq0 + nreq1;
        issue(32'd0, c_min_ts, 3, 1, 1'b0);
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done();
        repeat (10) step();
        @(negedge clock);
        chk("busy_start_reads", 72'(nreq0 + nreq1 - n), 72'd2);
        chk("no_rerun", 72'({done, busy}), 72'(2'b10));
        run_check(32'd0, c_min_ts + 32'd100, 0, 1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
